mem_arbiter: RTL and testbench

- Shares the single 32-bit memory port of the core between two requesters: instruction fetch (IF) and load/store (LS).
- Sits between the fetch/execute logic and the memory bus.
- Serialises accesses with exactly one transaction outstanding, using a 2-way round-robin.
- Provides a bus timeout and fetch-misalignment error reporting.

---
 rtl/mem_arbiter_pkg.sv | 25 ++
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-requester memory port arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    MEM_ST_IDLE = 2'd0,
    MEM_ST_BUSY = 2'd1,
    MEM_ST_RESP = 2'd2
  } mem_state_e;

  typedef enum logic {
    MEM_GNT_IF = 1'b0,
    MEM_GNT_LS = 1'b1
  } mem_gnt_e;

  localparam logic [3:0] MEM_BE_WORD = 4'hF;

  // One bus access as presented on mem_*.
  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and load/store,
// one transaction outstanding, with bus timeout and misaligned-fetch errors.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_ready_o,
  output logic [31:0] if_rdata_o,
  output logic        if_err_o,
  input  logic        ls_req_i,
  input  logic        ls_we_i,
  input  logic [3:0]  ls_be_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  output logic        ls_ready_o,
  output logic [31:0] ls_rdata_o,
  output logic        ls_err_o,
  output logic        mem_valid_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i
);

  mem_state_e  state, state_nxt;
  mem_gnt_e    gnt, last_gnt, pick;
  mem_req_t    bus, req_nxt;
  logic [15:0] cnt;
  logic        grant, misalign, timeout, done;
  logic        mem_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] if_rdata, ls_rdata;
  logic        if_err, ls_err;

  // Contention goes to whoever was not served last.
  always_comb begin
    pick = MEM_GNT_IF;
    if (if_req_i && ls_req_i) pick = (last_gnt == MEM_GNT_IF) ? MEM_GNT_LS : MEM_GNT_IF;
    else if (ls_req_i)        pick = MEM_GNT_LS;
  end

  assign grant    = (state == MEM_ST_IDLE) && (if_req_i || ls_req_i);
  assign misalign = (pick == MEM_GNT_IF) && (if_addr_i[1:0] != 2'b00);
  assign timeout  = (cnt == 16'(TIMEOUT_CYCLES - 1));
  assign done     = mem_ready_i || timeout;

  always_comb begin
    req_nxt = '{we: 1'b0, be: MEM_BE_WORD, addr: if_addr_i, wdata: 32'h0};
    if (pick == MEM_GNT_LS)
      req_nxt = '{we: ls_we_i, be: ls_be_i, addr: ls_addr_i, wdata: ls_wdata_i};
  end

  // Ready wins over a coincident timeout; stores return zero data.
  always_comb begin
    resp_err   = !mem_ready_i;
    resp_rdata = (mem_ready_i && !bus.we) ? mem_rdata_i : 32'h0;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= MEM_ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      MEM_ST_IDLE: if (grant) state_nxt = misalign ? MEM_ST_RESP : MEM_ST_BUSY;
      MEM_ST_BUSY: if (done)  state_nxt = MEM_ST_RESP;
      MEM_ST_RESP: state_nxt = MEM_ST_IDLE;
      default:     state_nxt = MEM_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      gnt       <= MEM_GNT_IF;
      last_gnt  <= MEM_GNT_LS;
      cnt       <= '0;
      bus       <= '0;
      mem_valid <= 1'b0;
      if_rdata  <= '0;
      if_err    <= 1'b0;
      ls_rdata  <= '0;
      ls_err    <= 1'b0;
    end else begin
      unique case (state)
        MEM_ST_IDLE: if (grant) begin
          gnt      <= pick;
          last_gnt <= pick;
          cnt      <= '0;
          if (misalign) begin
            if_rdata <= '0;
            if_err   <= 1'b1;
          end else begin
            bus       <= req_nxt;
            mem_valid <= 1'b1;
          end
        end
        MEM_ST_BUSY: if (done) begin
          mem_valid <= 1'b0;
          if (gnt == MEM_GNT_IF) begin
            if_rdata <= resp_rdata;
            if_err   <= resp_err;
          end else begin
            ls_rdata <= resp_rdata;
            ls_err   <= resp_err;
          end
        end else begin
          cnt <= cnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign mem_valid_o = mem_valid;
  assign mem_we_o    = bus.we;
  assign mem_be_o    = bus.be;
  assign mem_addr_o  = bus.addr;
  assign mem_wdata_o = bus.wdata;

  assign if_ready_o  = (state == MEM_ST_RESP) && (gnt == MEM_GNT_IF);
  assign ls_ready_o  = (state == MEM_ST_RESP) && (gnt == MEM_GNT_LS);
  assign if_rdata_o  = if_rdata;
  assign if_err_o    = if_err;
  assign ls_rdata_o  = ls_rdata;
  assign ls_err_o    = ls_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench: a transaction-timing model predicts bus
// accesses and completions; a negedge monitor pops and compares them.
module tb_mem_arbiter;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_ready_o;
  logic [31:0] if_rdata_o;
  logic        if_err_o;
  logic        ls_req_i, ls_we_i;
  logic [3:0]  ls_be_i;
  logic [31:0] ls_addr_i, ls_wdata_i;
  logic        ls_ready_o;
  logic [31:0] ls_rdata_o;
  logic        ls_err_o;
  logic        mem_valid_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ready_i;
  logic [31:0] mem_rdata_i;

  mem_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk), .rstn_i(rstn_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ready_o(if_ready_o),
    .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_be_i(ls_be_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_ready_o(ls_ready_o), .ls_rdata_o(ls_rdata_o),
    .ls_err_o(ls_err_o),
    .mem_valid_o(mem_valid_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          first;
    int          last_;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    bit          who;   // 0 = fetch, 1 = load/store
    int          at;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  bus_t  bus_q[$];
  resp_t resp_q[$];
  bus_t  cur;
  int    checks = 0, errors = 0;
  int    e = 0;
  int    idle_edge = 0, rdy_edge = -1, busy_lo = 1, busy_hi = 0;
  bit    m_last = 1'b1;
  logic [31:0] rdy_data;
  bit    mon_en = 0, gen_en = 0, in_bus = 0, if_done = 0, ls_done = 0;
  logic [31:0] hold_if_rd = 0, hold_ls_rd = 0;
  logic        hold_if_err = 0, hold_ls_err = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, e, act, exp);
    end
  endfunction

  task automatic new_if();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 5) != 0) r[1:0] = 2'b00;
    else if (r[1:0] == 2'b00)      r[1:0] = 2'b10;
    if_addr_i = r;
    if_req_i  = 1'b1;
  endtask

  task automatic new_ls();
    logic [31:0] r;
    r = $urandom;
    ls_be_i    = r[3:0];
    ls_we_i    = r[4];
    ls_addr_i  = $urandom;
    ls_wdata_i = $urandom;
    ls_req_i   = 1'b1;
  endtask

  // One clock: model the arbiter decision at this edge, then drive new inputs.
  task automatic step();
    bit          who;
    int          d;
    bus_t        b;
    logic [31:0] r;
    @(posedge clk);
    e++;
    if (e >= idle_edge && (if_req_i || ls_req_i)) begin
      who    = (if_req_i && ls_req_i) ? ~m_last : ls_req_i;
      m_last = who;
      if (!who && if_addr_i[1:0] != 2'b00) begin
        resp_q.push_back('{1'b0, e, 32'h0, 1'b1});
        idle_edge = e + 2;
      end else begin
        d        = $urandom_range(0, T + 2);
        rdy_data = $urandom;
        b.first  = e;
        b.last_  = (d < T) ? e + d + 1 : e + T;
        b.we     = who ? ls_we_i    : 1'b0;
        b.be     = who ? ls_be_i    : 4'hF;
        b.addr   = who ? ls_addr_i  : if_addr_i;
        b.wdata  = who ? ls_wdata_i : 32'h0;
        bus_q.push_back(b);
        rdy_edge = (d < T) ? b.last_ : -1;
        busy_lo  = e + 1;
        busy_hi  = b.last_;
        resp_q.push_back('{who, b.last_, (d < T && !b.we) ? rdy_data : 32'h0, d >= T});
        idle_edge = b.last_ + 2;
      end
    end
    #1;
    if (if_done) begin if_done = 0; if_req_i = 1'b0; end
    if (ls_done) begin ls_done = 0; ls_req_i = 1'b0; end
    if (!if_req_i && gen_en && $urandom_range(0, 2) != 0) new_if();
    if (!ls_req_i && gen_en && $urandom_range(0, 2) != 0) new_ls();
    if (e + 1 == rdy_edge) begin
      mem_ready_i = 1'b1;
      mem_rdata_i = rdy_data;
    end else begin
      r = $urandom;
      mem_rdata_i = r;
      mem_ready_i = !(e + 1 >= busy_lo && e + 1 <= busy_hi) && ($urandom_range(0, 3) == 0);
    end
  endtask

  always @(negedge clk) if (mon_en) begin
    resp_t rs;
    if (if_ready_o || ls_ready_o) begin
      chk("single_ready", {30'h0, if_ready_o, ls_ready_o} == 32'h3, 32'h0);
      if (resp_q.size() == 0) chk("unexpected_ready", {31'h0, ls_ready_o}, 32'hFFFF_FFFF);
      else begin
        rs = resp_q.pop_front();
        chk("resp_who", {31'h0, ls_ready_o}, {31'h0, rs.who});
        chk("resp_edge", e, rs.at);
        if (rs.who) begin hold_ls_rd = rs.rdata; hold_ls_err = rs.err; end
        else        begin hold_if_rd = rs.rdata; hold_if_err = rs.err; end
      end
      if (if_ready_o) if_done = 1;
      if (ls_ready_o) ls_done = 1;
    end else if (resp_q.size() > 0 && resp_q[0].at < e) begin
      chk("resp_missing", e, resp_q[0].at);
      void'(resp_q.pop_front());
    end
    chk("if_rdata", if_rdata_o, hold_if_rd);
    chk("if_err", {31'h0, if_err_o}, {31'h0, hold_if_err});
    chk("ls_rdata", ls_rdata_o, hold_ls_rd);
    chk("ls_err", {31'h0, ls_err_o}, {31'h0, hold_ls_err});
    if (mem_valid_o) begin
      if (!in_bus) begin
        if (bus_q.size() == 0) chk("unexpected_valid", {31'h0, mem_valid_o}, 32'h0);
        else begin
          cur = bus_q.pop_front();
          in_bus = 1;
          chk("valid_start", e, cur.first);
        end
      end
      if (in_bus) begin
        chk("mem_addr", mem_addr_o, cur.addr);
        chk("mem_we", {31'h0, mem_we_o}, {31'h0, cur.we});
        chk("mem_be", {28'h0, mem_be_o}, {28'h0, cur.be});
        chk("mem_wdata", mem_wdata_o, cur.wdata);
      end
    end else if (in_bus) begin
      chk("valid_end", e, cur.last_);
      in_bus = 0;
    end else if (bus_q.size() > 0 && bus_q[0].first < e) begin
      chk("valid_missing", e, bus_q[0].first);
      void'(bus_q.pop_front());
    end
  end

  task automatic check_idle_outputs(string tag);
    chk({tag, "_mem_valid"}, {31'h0, mem_valid_o}, 32'h0);
    chk({tag, "_if_ready"},  {31'h0, if_ready_o}, 32'h0);
    chk({tag, "_ls_ready"},  {31'h0, ls_ready_o}, 32'h0);
    chk({tag, "_if_rdata"},  if_rdata_o, 32'h0);
    chk({tag, "_ls_rdata"},  ls_rdata_o, 32'h0);
    chk({tag, "_if_err"},    {31'h0, if_err_o}, 32'h0);
    chk({tag, "_ls_err"},    {31'h0, ls_err_o}, 32'h0);
    chk({tag, "_mem_addr"},  mem_addr_o, 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata_o, 32'h0);
  endtask

  task automatic start_contention();
    if_addr_i = 32'h100;  if_req_i = 1'b1;
    ls_addr_i = 32'h2000; ls_we_i = 1'b1; ls_be_i = 4'b0011; ls_wdata_i = 32'h1234;
    ls_req_i  = 1'b1;
    m_last = 1'b1; idle_edge = 0; rdy_edge = -1; busy_lo = 1; busy_hi = 0;
  endtask

  initial begin
    bit seen;
    rstn_i = 1'b0; if_req_i = 1'b0; if_addr_i = '0; ls_req_i = 1'b0; ls_we_i = 1'b0;
    ls_be_i = '0; ls_addr_i = '0; ls_wdata_i = '0; mem_ready_i = 1'b0; mem_rdata_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    start_contention();
    rstn_i = 1'b1;
    mon_en = 1; gen_en = 1;
    repeat (2000) step();

    // Abort a transaction in flight with an asynchronous reset.
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step();
      seen = mem_valid_o;
    end
    chk("wait_valid", {31'h0, seen}, 32'h1);
    mon_en = 0;
    #1 rstn_i = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    bus_q.delete(); resp_q.delete();
    in_bus = 0; if_done = 0; ls_done = 0;
    hold_if_rd = 0; hold_ls_rd = 0; hold_if_err = 0; hold_ls_err = 0;
    if_req_i = 1'b0; ls_req_i = 1'b0; mem_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("in_rst");
    @(posedge clk);
    #1;
    start_contention();
    rstn_i = 1'b1;
    mon_en = 1;
    repeat (2000) step();

    gen_en = 0;
    for (int i = 0; i < 200; i++) begin
      if (!if_req_i && !ls_req_i && resp_q.size() == 0 && bus_q.size() == 0 && !in_bus) break;
      step();
    end
    chk("drain_resp_q", resp_q.size(), 32'h0);
    chk("drain_bus_q", bus_q.size(), 32'h0);
    chk("drain_reqs", {30'h0, if_req_i, ls_req_i}, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
